// File: rtl/channel_pkg.sv
// caravel_channel shared constants, register map and helpers.
// Debug ports on the top are built only with CHANNEL_DEBUG_OUT_EN.
package channel_pkg;

  localparam int NCO_W = 32;
  localparam int ACC_W = 24;

  localparam logic [4:0] OFS_CTRL   = 5'h00;
  localparam logic [4:0] OFS_CARR   = 5'h04;
  localparam logic [4:0] OFS_CODE   = 5'h08;
  localparam logic [4:0] OFS_TAPS   = 5'h0C;
  localparam logic [4:0] OFS_STATUS = 5'h10;
  localparam logic [4:0] OFS_I      = 5'h14;
  localparam logic [4:0] OFS_Q      = 5'h18;

  localparam logic [7:0]  TAPS_RST  = 8'h62;
  localparam logic [10:1] LFSR_INIT = 10'h3FF;
  localparam logic [9:0]  CHIP_LAST = 10'd1022;

  localparam logic signed [ACC_W-1:0] ACC_ONE =
    {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  // Out-of-range tap numbers fall back to stage 10.
  function automatic logic tap_bit(
    input logic [10:1] g,
    input logic [3:0]  s
  );
    logic b;
    case (s)
      4'd1:    b = g[1];
      4'd2:    b = g[2];
      4'd3:    b = g[3];
      4'd4:    b = g[4];
      4'd5:    b = g[5];
      4'd6:    b = g[6];
      4'd7:    b = g[7];
      4'd8:    b = g[8];
      4'd9:    b = g[9];
      default: b = g[10];
    endcase
    return b;
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_step(
    input logic signed [ACC_W-1:0] a,
    input logic                    neg
  );
    logic signed [ACC_W-1:0] r;
    r = a;
    if (neg && a != ACC_MIN)
      r = a - ACC_ONE;
    else if (!neg && a != ACC_MAX)
      r = a + ACC_ONE;
    return r;
  endfunction

  function automatic logic [31:0] wb_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  sel
  );
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (d & m) | (old & ~m);
  endfunction

endpackage

// File: rtl/caravel_channel_if.sv
// Wishbone classic slave bundle for caravel_channel.
// Signal names follow the Caravel user-project port names.
interface caravel_channel_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/ca_code_gen.sv
// C/A code replica: G1/G2 LFSRs, tap select, chip counter, epoch flag.
// wrap is combinational so the epoch dump lands on the 1022->0 edge.
module ca_code_gen
  import channel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       restart,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic       chip,
  output logic       wrap
);

  logic [10:1] g1;
  logic [10:1] g2;
  logic [9:0]  cnt;
  logic        fb1;
  logic        fb2;

  assign fb1  = g1[3] ^ g1[10];
  assign fb2  = g2[2] ^ g2[3] ^ g2[6]
              ^ g2[8] ^ g2[9] ^ g2[10];
  assign wrap = step && (cnt == CHIP_LAST);
  assign chip = g1[10] ^ tap_bit(g2, s1)
              ^ tap_bit(g2, s2);

  always_ff @(posedge clk) begin
    if (rst || restart || wrap) begin
      g1  <= LFSR_INIT;
      g2  <= LFSR_INIT;
      cnt <= '0;
    end else if (step) begin
      g1  <= {g1[9:1], fb1};
      g2  <= {g2[9:1], fb2};
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/caravel_channel.sv
// Single-channel GPS L1 C/A correlator, Wishbone slave.
// CHANNEL_DEBUG_OUT_EN adds lo_q and epoch output ports.
module caravel_channel
  import channel_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  caravel_channel_if.slave wb,
  input  logic             sample,
  output logic             prompt_i,
  output logic             lo_i,
  output logic             irq_o
`ifdef CHANNEL_DEBUG_OUT_EN
  ,
  output logic             lo_q,
  output logic             epoch
`endif
);

  logic                    en;
  logic                    dump;
  logic                    ack;
  logic                    sample_q;
  logic [NCO_W-1:0]        carr_fcw;
  logic [NCO_W-1:0]        code_fcw;
  logic [NCO_W-1:0]        carr_ph;
  logic [NCO_W-1:0]        code_ph;
  logic [NCO_W-1:0]        code_sum;
  logic                    code_cy;
  logic [7:0]              taps;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] dmp_i;
  logic signed [ACC_W-1:0] dmp_q;
  logic signed [ACC_W-1:0] nxt_i;
  logic signed [ACC_W-1:0] nxt_q;
  logic [31:0]             rd_q;
  logic [31:0]             rd_d;
  logic [2:0]              idx;
  logic                    access;
  logic                    wr;
  logic                    restart;
  logic                    clr;
  logic                    step;
  logic                    wrap;
  logic                    chip;
  logic                    unused_adr;
`ifndef CHANNEL_DEBUG_OUT_EN
  logic                    lo_q;
`endif

  assign idx     = wb.wbs_adr_i[4:2];
  assign access  = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack;
  assign wr      = access & wb.wbs_we_i;
  assign restart = wr && idx == OFS_CTRL[4:2]
                && wb.wbs_sel_i[0] && wb.wbs_dat_i[0] && !en;
  assign clr     = wr && idx == OFS_STATUS[4:2]
                && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];

  assign {code_cy, code_sum} = {1'b0, code_ph} + {1'b0, code_fcw};
  assign step = en & code_cy;

  assign lo_i  = ~(carr_ph[31] ^ carr_ph[30]);
  assign lo_q  = ~carr_ph[31];
  assign nxt_i = acc_step(acc_i, sample_q ^ chip ^ lo_i);
  assign nxt_q = acc_step(acc_q, sample_q ^ chip ^ lo_q);

  assign prompt_i     = chip;
  assign irq_o        = dump;
  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = rd_q;
  assign unused_adr   = ^{wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0]};

  ca_code_gen u_code (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .step    (step),
    .restart (restart),
    .s1      (taps[3:0]),
    .s2      (taps[7:4]),
    .chip    (chip),
    .wrap    (wrap)
  );

  always_comb begin
    rd_d = '0;
    case (idx)
      OFS_CTRL[4:2]:   rd_d = {31'b0, en};
      OFS_CARR[4:2]:   rd_d = carr_fcw;
      OFS_CODE[4:2]:   rd_d = code_fcw;
      OFS_TAPS[4:2]:   rd_d = {24'b0, taps};
      OFS_STATUS[4:2]: rd_d = {31'b0, dump};
      OFS_I[4:2]:      rd_d = {{(32-ACC_W){dmp_i[ACC_W-1]}}, dmp_i};
      OFS_Q[4:2]:      rd_d = {{(32-ACC_W){dmp_q[ACC_W-1]}}, dmp_q};
      default:         rd_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en       <= 1'b0;
      dump     <= 1'b0;
      ack      <= 1'b0;
      sample_q <= 1'b0;
      rd_q     <= '0;
      carr_fcw <= '0;
      code_fcw <= '0;
      taps     <= TAPS_RST;
      carr_ph  <= '0;
      code_ph  <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
      dmp_i    <= '0;
      dmp_q    <= '0;
    end else begin
      sample_q <= sample;
      ack      <= access;
      if (access)
        rd_q <= rd_d;
      if (wr) begin
        case (idx)
          OFS_CTRL[4:2]:
            if (wb.wbs_sel_i[0]) en <= wb.wbs_dat_i[0];
          OFS_CARR[4:2]:
            carr_fcw <= wb_merge(carr_fcw, wb.wbs_dat_i, wb.wbs_sel_i);
          OFS_CODE[4:2]:
            code_fcw <= wb_merge(code_fcw, wb.wbs_dat_i, wb.wbs_sel_i);
          OFS_TAPS[4:2]:
            if (wb.wbs_sel_i[0]) taps <= wb.wbs_dat_i[7:0];
          default: ;
        endcase
      end
      // a dump set outranks a simultaneous clear
      if (wrap)
        dump <= 1'b1;
      else if (clr)
        dump <= 1'b0;
      if (restart) begin
        carr_ph <= '0;
        code_ph <= '0;
        acc_i   <= '0;
        acc_q   <= '0;
      end else if (en) begin
        carr_ph <= carr_ph + carr_fcw;
        code_ph <= code_sum;
        if (wrap) begin
          dmp_i <= nxt_i;
          dmp_q <= nxt_q;
          acc_i <= '0;
          acc_q <= '0;
        end else begin
          acc_i <= nxt_i;
          acc_q <= nxt_q;
        end
      end
    end
  end

`ifdef CHANNEL_DEBUG_OUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      epoch <= 1'b0;
    else
      epoch <= wrap;
  end
`endif

endmodule

// File: tb/tb_caravel_channel.sv
// Self-checking bench for caravel_channel: directed register/epoch
// checks plus randomized runs against a sequence-level model.
module tb_caravel_channel;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [7:0]  A_CTRL = 8'h00;
  localparam logic [7:0]  A_CARR = 8'h04;
  localparam logic [7:0]  A_CODE = 8'h08;
  localparam logic [7:0]  A_TAPS = 8'h0C;
  localparam logic [7:0]  A_STAT = 8'h10;
  localparam logic [7:0]  A_I    = 8'h14;
  localparam logic [7:0]  A_Q    = 8'h18;

  localparam logic [7:0]  RA [7] = '{8'h00, 8'h04, 8'h08, 8'h0C,
                                     8'h10, 8'h14, 8'h18};
  localparam logic [31:0] RV [7] = '{32'h0, 32'h0, 32'h0, 32'h62,
                                     32'h0, 32'h0, 32'h0};
  localparam bit CA1 [10] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  localparam bit LO4 [4]  = '{1, 0, 0, 1};

  logic clk = 1'b0;
  logic rst;
  logic sample;
  logic prompt_i;
  logic lo_i;
  logic irq_o;
`ifdef CHANNEL_DEBUG_OUT_EN
  logic lo_q;
  logic epoch;
`endif

  int n_run   = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  bit ga [0:1039];
  bit gb [0:1039];

  caravel_channel_if wb();

  caravel_channel dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .sample   (sample),
    .prompt_i (prompt_i),
    .lo_i     (lo_i),
    .irq_o    (irq_o)
`ifdef CHANNEL_DEBUG_OUT_EN
    ,
    .lo_q     (lo_q),
    .epoch    (epoch)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // G1/G2 output sequences from their recurrences, starting all-ones
  task automatic build_seq();
    for (int k = 0; k < 10; k++) begin
      ga[k] = 1'b1;
      gb[k] = 1'b1;
    end
    for (int k = 0; k < 1030; k++) begin
      ga[k+10] = ga[k] ^ ga[k+7];
      gb[k+10] = gb[k] ^ gb[k+1] ^ gb[k+2]
               ^ gb[k+4] ^ gb[k+7] ^ gb[k+8];
    end
  endtask

  function automatic bit model_chip(input int k, input int s1,
                                    input int s2);
    int e1;
    int e2;
    e1 = (s1 >= 1 && s1 <= 10) ? s1 : 10;
    e2 = (s2 >= 1 && s2 <= 10) ? s2 : 10;
    return ga[k] ^ gb[k+10-e1] ^ gb[k+10-e2];
  endfunction

  task automatic wb_xfer(input logic we, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] sel,
                         output logic [31:0] q);
    bit got;
    got = 0;
    q   = '0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = BASE | {24'h0, a};
    wb.wbs_dat_i = d;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o) begin
        got = 1;
        q   = wb.wbs_dat_o;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    if (!got) check("wb_ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, 4'hF, q);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'h0, 4'hF, q);
  endtask

  task automatic wait_irq(output int t);
    bit got;
    got = 0;
    t   = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(posedge clk);
      #1;
      if (irq_o) begin
        got = 1;
        t   = cyc_cnt;
      end
    end
    if (!got) check("irq_timeout", 32'(got), 32'd1);
  endtask

  task automatic rnd_trial(input int t);
    logic [31:0] cf;
    logic [31:0] pf;
    logic [31:0] ph;
    logic [31:0] q;
    int s1, s2, ai, aq, ei, eq, perr, lerr;
    bit sq, sn, ch, li, lq, hit;
    longint unsigned kc, kn;
    cf = $urandom;
    pf = $urandom_range(32'hFFFF_FFFF, 32'h8000_0000);
    s1 = $urandom_range(0, 12);
    s2 = $urandom_range(0, 12);
    sq = 1'($urandom_range(0, 1));
    sample = sq;
    wb_write(A_CTRL, 32'd0);
    wb_write(A_CARR, cf);
    wb_write(A_CODE, pf);
    wb_write(A_TAPS, {24'h0, 4'(s2), 4'(s1)});
    wb_write(A_STAT, 32'd1);
    wb_write(A_CTRL, 32'd1);
    ai = 0; aq = 0; ei = 0; eq = 0;
    perr = 0; lerr = 0; hit = 0;
    for (int n = 0; n < 2100 && !hit; n++) begin
      kc = (64'(n) * 64'(pf)) >> 32;
      ph = 32'(64'(n) * 64'(cf));
      li = ~(ph[31] ^ ph[30]);
      lq = ~ph[31];
      ch = model_chip(int'(kc % 1023), s1, s2);
      if (prompt_i !== ch) perr++;
      if (lo_i !== li) lerr++;
      sn = 1'($urandom_range(0, 1));
      sample = sn;
      ai += (sq ^ ch ^ li) ? -1 : 1;
      aq += (sq ^ ch ^ lq) ? -1 : 1;
      if (ai > 8388607) ai = 8388607;
      if (ai < -8388607) ai = -8388607;
      if (aq > 8388607) aq = 8388607;
      if (aq < -8388607) aq = -8388607;
      kn = (64'(n + 1) * 64'(pf)) >> 32;
      if (kn != kc && kn % 1023 == 0) begin
        hit = 1;
        ei  = ai;
        eq  = aq;
      end
      @(posedge clk);
      #1;
      sq = sn;
    end
    check($sformatf("rnd%0d_prompt_errs", t), 32'(perr), 32'd0);
    check($sformatf("rnd%0d_lo_errs", t), 32'(lerr), 32'd0);
    check($sformatf("rnd%0d_irq", t), 32'(irq_o), 32'(hit));
    wb_read(A_I, q);
    check($sformatf("rnd%0d_i", t), q, 32'(ei));
    wb_read(A_Q, q);
    check($sformatf("rnd%0d_q", t), q, 32'(eq));
  endtask

  initial begin
    logic [31:0] q;
    int t0, t1, t2;
    build_seq();
    rst          = 1'b1;
    sample       = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    check("rst_prompt", 32'(prompt_i), 32'd1);
    check("rst_lo", 32'(lo_i), 32'd1);
    check("rst_irq", 32'(irq_o), 32'd0);
    for (int i = 0; i < 7; i++) begin
      wb_read(RA[i], q);
      check($sformatf("rst_reg_%02h", RA[i]), q, RV[i]);
    end

    wb_write(A_CODE, 32'h8000_0000);
    wb_write(A_CTRL, 32'd1);
    for (int n = 0; n < 20; n++) begin
      check($sformatf("code_cyc%0d", n), 32'(prompt_i),
            32'(CA1[n/2]));
      @(posedge clk);
      #1;
    end

    wb_write(A_CTRL, 32'd0);
    wb_write(A_CODE, 32'd0);
    wb_write(A_CARR, 32'h4000_0000);
    wb_write(A_CTRL, 32'd1);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("carr_cyc%0d", n), 32'(lo_i), 32'(LO4[n%4]));
      @(posedge clk);
      #1;
    end

    wb_write(A_CTRL, 32'd0);
    wb_write(A_CARR, 32'd0);
    wb_write(A_CODE, 32'h8000_0000);
    sample = 1'b1;
    wb_write(A_STAT, 32'd1);
    wb_write(A_CTRL, 32'd1);
    t0 = cyc_cnt;
    wait_irq(t1);
    check("corr_cycles", 32'(t1 - t0), 32'd2046);
    wb_read(A_I, q);
    check("corr_i", q, 32'hFFFF_FFFE);
    wb_read(A_Q, q);
    check("corr_q", q, 32'hFFFF_FFFE);
    wb_read(A_STAT, q);
    check("corr_status", q, 32'd1);

    wb_write(A_STAT, 32'd1);
    check("clr_irq", 32'(irq_o), 32'd0);
    wait_irq(t2);
    check("epoch_period", 32'(t2 - t1), 32'd2046);
    wb_read(A_I, q);
    check("epoch2_i", q, 32'hFFFF_FFFE);
    wb_read(A_Q, q);
    check("epoch2_q", q, 32'hFFFF_FFFE);

    wb_write(A_CTRL, 32'd0);
    wb_write(A_CTRL, 32'd1);
    t0 = cyc_cnt;
    for (int n = 0; n < 10; n++) begin
      check($sformatf("restart_cyc%0d", n), 32'(prompt_i),
            32'(CA1[n/2]));
      @(posedge clk);
      #1;
    end
    wb_write(A_STAT, 32'd1);
    wait_irq(t1);
    check("restart_cycles", 32'(t1 - t0), 32'd2046);
    wb_read(A_I, q);
    check("restart_i", q, 32'hFFFF_FFFE);
    wb_read(A_Q, q);
    check("restart_q", q, 32'hFFFF_FFFE);

    wb_write(A_CTRL, 32'd0);
    wb_write(A_CARR, 32'h1122_3344);
    wb_xfer(1'b1, A_CARR, 32'hAABB_CCDD, 4'b0101, q);
    wb_read(A_CARR, q);
    check("sel_merge", q, 32'h11BB_33DD);

    for (int t = 0; t < 3; t++)
      rnd_trial(t);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_irq", 32'(irq_o), 32'd0);
    check("rst2_prompt", 32'(prompt_i), 32'd1);
    wb_read(A_I, q);
    check("rst2_i", q, 32'd0);
    wb_read(A_CTRL, q);
    check("rst2_ctrl", q, 32'd0);
    wb_read(A_TAPS, q);
    check("rst2_taps", q, 32'h62);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/caravel_channel.md
# caravel_channel

Single-channel GPS L1 C/A correlator that sits in the Caravel user project area as a Wishbone slave. It generates a local carrier (NCO) and a PRN code replica (code NCO plus G1/G2 LFSRs), correlates a 1-bit sampled IF input against them, and dumps prompt I/Q sums once per 1023-chip code epoch. Firmware on the management core configures it and reads results over Wishbone. `prompt_i` and `lo_i` are brought out to `mprj_io` pins for observation.

## Interface
- No parameters; widths fixed (NCOs 32 bit, accumulators 24 bit signed).
- `wb_clk_i` in 1: the only clock, also the sample clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic controls.
- `wbs_sel_i` in 4: byte enables, honoured on writes.
- `wbs_adr_i` in 32: word address; bits [4:2] decode the register, other bits ignored.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `sample` in 1: IF sign bit; 0 means +1, 1 means −1.
- `prompt_i` out 1: current PRN chip.
- `lo_i` out 1: in-phase carrier sign.
- `irq_o` out 1: equals `STATUS.dump`.

## Operation
- Registers (byte offset, reset value):
  - 0x00 `CTRL`, 0: bit0 `en`. A 0→1 write restarts the channel: phases=0, LFSRs=all-ones, chip count=0, accumulators=0.
  - 0x04 `CARR_FCW`, 0.
  - 0x08 `CODE_FCW`, 0.
  - 0x0C `PRN_TAPS`, 0x62: [3:0] = s1, [7:4] = s2, each 1..10. Default is PRN1.
  - 0x10 `STATUS`: bit0 `dump`. Writing 1 clears it.
  - 0x14 `I_PROMPT`, 0x18 `Q_PROMPT`: read-only, sign-extended 24-bit dumps.
- Per enabled cycle: `carr_ph += CARR_FCW` and `code_ph += CODE_FCW`, both mod 2^32.
- Carry-out of `code_ph` advances both LFSRs one step and increments the chip count (0..1022).
- LFSR bits are indexed 1..10 and shift toward 10.
  - G1 feedback: G1[3]^G1[10].
  - G2 feedback: G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10].
  - chip = G1[10]^G2[s1]^G2[s2].
- `lo_i` = ~(carr_ph[31]^carr_ph[30]). `lo_q` = ~carr_ph[31] (internal).
- `sample` is registered once to give `sample_q`.
- Each enabled cycle:
  - I += (sample_q^chip^lo_i) ? −1 : +1.
  - Q += (sample_q^chip^lo_q) ? −1 : +1.
  - Both accumulators saturate at ±(2^23−1).
- Epoch: when a code step moves the chip count from 1022 to 0:
  - LFSRs reload all-ones.
  - I/Q (including this cycle's term) are copied to `I_PROMPT`/`Q_PROMPT`.
  - Accumulators restart at 0 and `dump` is set.
  - A dump overwrites unread results. If a clear and a set coincide, the set wins.
- With `en`=0, all state holds and nothing accumulates.
- Invalid tap values (0 or >10) select G2[10].

## Timing
- Wishbone: `wbs_ack_o` pulses one cycle after `cyc&stb` with no ack pending. Read data is valid with ack. A write takes effect on the ack edge.
- `prompt_i`/`lo_i` are combinational from state registers, so they change on the clock edge that updates the state.
- `sample` reaches the accumulator one cycle after it arrives.
- Epoch results are readable on the cycle after the 1022→0 step.
- Reset values:
  - `prompt_i`=1 (1^1^1), `lo_i`=1.
  - `wbs_ack_o`=0, `irq_o`=0.
  - All registers as listed above.
- Reset mid-epoch discards the partial sums.

## Configuration
- `CHANNEL_DEBUG_OUT_EN` defined: adds output ports `lo_q` (1 bit) and `epoch` (1-cycle pulse on each dump).
- Undefined: neither port exists and the logic is unchanged.

## Structure
- `channel_pkg` holds:
  - register offsets;
  - reset constants (PRN1 taps 0x62, LFSR init 10'h3FF);
  - widths (NCO 32, ACC 24);
  - the chip-count terminal value 1022.
- One sub-module, `ca_code_gen`: G1/G2 LFSRs, tap select, chip counter and epoch flag. It takes step, restart and taps as inputs.

## Test plan
- Reset: assert `wb_rst_i` 2 cycles, then read all registers → reset values listed above; `prompt_i`=1, `lo_i`=1, `irq_o`=0.
- Code replica: default taps, `CODE_FCW`=0x8000_0000, `en`=1 → `prompt_i` first 10 chips are 1,1,0,0,1,0,0,0,0,0, each held 2 cycles.
- Carrier: `CARR_FCW`=0x4000_0000, `en`=1 → `lo_i` repeats 1,0,0,1 with period 4 cycles.
- Correlation: `CARR_FCW`=0, `CODE_FCW`=0x8000_0000, `sample`=1 → `dump`/`irq_o` rise after 2046 enabled cycles; `I_PROMPT`=`Q_PROMPT`=0xFFFF_FFFE (−2).
- Dump clear: write `STATUS`=1 → `irq_o` drops. The next epoch, 2046 cycles later, sets it again with the same values.
- Restart: toggle `en` 1→0→1 mid-epoch → chip sequence restarts from 1,1,0,0,1; the next dump is still −2/−2.
